// File: rtl/busmatrix_pkg.sv
// Shared AHB encodings and default widths for the bus matrix.
// No logic; constants and types only.
// Imported by every matrix stage.
package busmatrix_pkg;

    localparam int BM_AW = 32;
    localparam int BM_MW = 4;
    localparam int BM_UW = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

endpackage

// File: rtl/busmatrix_input_stage.sv
// Per-slave-port input stage: presents the master's address phase, holding it if the output stage is busy.
// Latency: zero for an uncontended transfer; a held transfer is presented from the cycle after capture.
// Backpressure: HREADYOUTS is low while a transfer is held; the hold releases the edge after active_in.
module busmatrix_input_stage
    import busmatrix_pkg::*;
#(
    parameter int AW = BM_AW,
    parameter int MW = BM_MW,
    parameter int UW = BM_UW
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSELS,
    input  logic [AW-1:0] HADDRS,
    input  logic [1:0]    HTRANSS,
    input  logic          HWRITES,
    input  logic [2:0]    HSIZES,
    input  logic [2:0]    HBURSTS,
    input  logic [3:0]    HPROTS,
    input  logic [MW-1:0] HMASTERS,
    input  logic          HMASTLOCKS,
    input  logic [UW-1:0] HAUSERS,
    input  logic          HREADYS,
    input  logic          active_in,
    input  logic          readyout_in,
    input  logic [1:0]    resp_in,
    output logic          sel_in,
    output logic [AW-1:0] addr_in,
    output logic [1:0]    trans_in,
    output logic          write_in,
    output logic [2:0]    size_in,
    output logic [2:0]    burst_in,
    output logic [3:0]    prot_in,
    output logic [MW-1:0] master_in,
    output logic          mastlock_in,
    output logic [UW-1:0] auser_in,
    output logic          held_tran_in,
    output logic          HREADYOUTS,
    output logic [1:0]    HRESPS
);

    typedef struct packed {
        logic          sel;
        logic [AW-1:0] addr;
        logic [1:0]    trans;
        logic          write;
        logic [2:0]    size;
        logic [2:0]    burst;
        logic [3:0]    prot;
        logic [MW-1:0] master;
        logic          mastlock;
        logic [UW-1:0] auser;
    } aphase_t;

    aphase_t live;
    aphase_t hold_q, hold_d;
    aphase_t pres;
    logic    pend_q, pend_d;
    logic    new_tran;

    // Bundle the master's live address-phase inputs.
    always_comb begin
        live.sel      = HSELS;
        live.addr     = HADDRS;
        live.trans    = HTRANSS;
        live.write    = HWRITES;
        live.size     = HSIZES;
        live.burst    = HBURSTS;
        live.prot     = HPROTS;
        live.master   = HMASTERS;
        live.mastlock = HMASTLOCKS;
        live.auser    = HAUSERS;
    end

    assign new_tran = HSELS & HTRANSS[1] & HREADYS;

    // Next state: holding register follows every accepted address phase; pend tracks an unserved one.
    always_comb begin
        hold_d = hold_q;
        pend_d = pend_q;
        if (HRESET) begin
            hold_d = '0;
            pend_d = 1'b0;
        end else begin
            if (HREADYS) begin
                hold_d = live;
            end
            if (new_tran && !active_in) begin
                pend_d = 1'b1;
            end else if (pend_q && active_in) begin
                pend_d = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge HCLK) begin
        hold_q <= hold_d;
        pend_q <= pend_d;
    end

    // Output mux; a held transfer restarts as NONSEQ because the stall broke any burst.
    always_comb begin
        pres       = live;
        HREADYOUTS = readyout_in;
        HRESPS     = resp_in;
        if (HRESET) begin
            pres       = '0;
            HREADYOUTS = 1'b1;
            HRESPS     = HRESP_OKAY;
        end else if (pend_q) begin
            pres       = hold_q;
            pres.sel   = 1'b1;
            pres.trans = HTRANS_NONSEQ;
            HREADYOUTS = 1'b0;
            HRESPS     = HRESP_OKAY;
        end
    end

    assign held_tran_in = pend_q & ~HRESET;
    assign sel_in       = pres.sel;
    assign addr_in      = pres.addr;
    assign trans_in     = pres.trans;
    assign write_in     = pres.write;
    assign size_in      = pres.size;
    assign burst_in     = pres.burst;
    assign prot_in      = pres.prot;
    assign master_in    = pres.master;
    assign mastlock_in  = pres.mastlock;
    assign auser_in     = pres.auser;

endmodule

// File: doc/busmatrix_input_stage.md
# busmatrix_input_stage

Per-slave-port input stage of the AHB bus matrix. Sits between an external master (slave port S*n*) and that port's address decoder. It presents the master's address-phase signals to the decoder and output stages, and captures any transfer the targeted output stage cannot take immediately. It stalls the master with HREADYOUTS low until the held transfer is accepted, and returns the data-phase response from the decoder.

## Interface
Parameters:
- AW, 32, address width
- MW, 4, HMASTER width
- UW, 4, HAUSER width

Ports (clock and reset first):
- HCLK  in  1  AHB system clock
- HRESET  in  1  reset; synchronous and active-high
- HSELS  in  1  port select from master
- HADDRS  in  AW  address
- HTRANSS  in  2  transfer type
- HWRITES  in  1  write
- HSIZES  in  3  size
- HBURSTS  in  3  burst
- HPROTS  in  4  protection
- HMASTERS  in  MW  master id
- HMASTLOCKS  in  1  locked
- HAUSERS  in  UW  address user
- HREADYS  in  1  port HREADY (completion of previous data phase)
- active_in  in  1  decoder/output stage is sampling this port's address this cycle
- readyout_in  in  1  data-phase HREADYOUT from decoder
- resp_in  in  2  data-phase HRESP from decoder
- sel_in, addr_in, trans_in, write_in, size_in, burst_in, prot_in, master_in, mastlock_in, auser_in  out  widths as the corresponding inputs  address phase presented to decoder
- held_tran_in  out  1  a transfer is pending in the holding register
- HREADYOUTS  out  1  HREADY feedback to master
- HRESPS  out  2  response to master

## Operation
- Holding register: all address-phase inputs, loaded on every rising edge with HREADYS=1 and HRESET=0.
- new_tran = HSELS & HTRANSS[1] & HREADYS (NONSEQ=2'b10 or SEQ=2'b11).
- pend register: next = 1 when new_tran & ~active_in; next = 0 when pend & active_in; otherwise holds. Both conditions are never true together, because HREADYS is low while pend=1.
- Output mux:
  - pend=0: address outputs are the live master inputs, combinational.
  - pend=1: address outputs come from the holding register.
- Held SEQ is presented as trans_in=NONSEQ (2'b10). The burst is broken by the stall, so the output stage re-arbitrates. Held NONSEQ passes through unchanged.
- sel_in=1 whenever pend=1.
- held_tran_in = pend.
- HREADYOUTS = pend ? 0 : readyout_in.
- HRESPS = pend ? OKAY (2'b00) : resp_in.
- IDLE (2'b00) or BUSY (2'b01), or HSELS=0: never sets pend; passed through live.
- Reset: while HRESET=1, pend and all holding registers clear to 0 on each edge. Outputs are forced to HREADYOUTS=1, HRESPS=OKAY, sel_in=0, trans_in=IDLE, all other outputs 0.
- Reset asserted while pend=1: pend clears at that edge; the held transfer is discarded.

## Timing
- Zero added latency for an uncontended transfer: address is visible to the decoder in the master's address-phase cycle.
- Contended transfer:
  - Edge E0 captures it and sets pend.
  - From cycle E0+1: held address presented; HREADYOUTS=0.
  - First cycle with active_in=1: output stage samples the held address; pend clears at the following edge.
  - The data phase then proceeds with HREADYOUTS=readyout_in.
- Minimum stall for a held transfer is one wait state. Stall length is unbounded and follows active_in.
- No combinational path from HREADYS to HREADYOUTS.

## Structure
- Shared package busmatrix_pkg holds:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
  - HRESP OKAY/ERROR
  - default AW/MW/UW constants
- Single module; no sub-module. The holding register and mux are too small to split.

## Test plan
- Reset: HRESET=1 for 2 cycles with HSELS=1, HTRANSS=NONSEQ -> held_tran_in=0, HREADYOUTS=1, HRESPS=00, trans_in=00 throughout.
- Uncontended: NONSEQ read 0x0004_0000 with active_in=1 and HREADYS=1 -> addr_in=0x0004_0000 same cycle, held_tran_in stays 0, HREADYOUTS tracks readyout_in.
- Stall: NONSEQ write 0x2000_0100 with active_in=0 for 3 cycles, then 1 -> held_tran_in=1 and HREADYOUTS=0 for 3 cycles, addr_in=0x2000_0100, write_in=1. pend clears the edge after active_in=1, then HREADYOUTS=readyout_in.
- SEQ conversion: SEQ 0x0000_0104 captured with active_in=0 -> trans_in=2'b10 while held, addr_in=0x0000_0104.
- IDLE/BUSY with active_in=0 -> held_tran_in stays 0, HREADYOUTS=readyout_in.
- Reset mid-stall: HRESET=1 while held_tran_in=1 -> held_tran_in=0 and HREADYOUTS=1 after that edge; no stale transfer after release.
